// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point add/subtract, {sign, EXP_W exponent, MAN_W fraction}, hidden 1, no denormals.
// Define FP_RNE_EN for round-to-nearest-even; otherwise the result is truncated.
module fp_addsub_seq #(
  parameter int unsigned EXP_W = 4,
  parameter int unsigned MAN_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   op,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out,
  output logic                   ovf,
  output logic                   unf
);

  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  localparam int unsigned DW   = MAN_W + 4;            // hidden + fraction + guard/round/sticky
  localparam int unsigned EW   = EXP_W + 1;            // one spare bit to see overflow
  localparam int unsigned EMAX = (1 << EXP_W) - 1;
  localparam int unsigned CAP  = MAN_W + 3;
  localparam int unsigned CW   = $clog2(CAP + 1);

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;

  state_t          state;
  logic [W-1:0]    ra, rb;
  logic            sa, sb;
  logic [EW-1:0]   ea;
  logic [DW-1:0]   ma, mb;
  logic [CW-1:0]   cnt;

  logic [EXP_W-1:0] xa_e, xb_e, d;
  logic [MAN_W:0]   xa_m, xb_m;
  logic             swap;
  logic [DW:0]      sum;
  logic             rinc;
  logic [MAN_W+1:0] mrnd;
  logic [EW-1:0]    ea_inc;

  // Unpack/compare, adder and rounding increment
  always_comb begin
    xa_e   = ra[W-2 -: EXP_W];
    xb_e   = rb[W-2 -: EXP_W];
    xa_m   = (xa_e == '0) ? '0 : {1'b1, ra[MAN_W-1:0]};
    xb_m   = (xb_e == '0) ? '0 : {1'b1, rb[MAN_W-1:0]};
    swap   = {xb_e, xb_m} > {xa_e, xa_m};
    d      = swap ? (xb_e - xa_e) : (xa_e - xb_e);
    sum    = (sa == sb) ? ({1'b0, ma} + {1'b0, mb}) : ({1'b0, ma} - {1'b0, mb});
`ifdef FP_RNE_EN
    rinc   = ma[2] & (ma[1] | ma[0] | ma[3]);
`else
    rinc   = 1'b0;
`endif
    mrnd   = {1'b0, ma[DW-1:3]} + (MAN_W+2)'(rinc);
    ea_inc = ea + EW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      ra        <= '0;
      rb        <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      ea        <= '0;
      ma        <= '0;
      mb        <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ra       <= a;
            rb       <= b ^ {op, {(W-1){1'b0}}};
            in_ready <= 1'b0;
            state    <= UNPACK;
          end
        end
        UNPACK: begin
          sa    <= swap ? rb[W-1] : ra[W-1];
          sb    <= swap ? ra[W-1] : rb[W-1];
          ea    <= EW'(swap ? xb_e : xa_e);
          ma    <= {(swap ? xb_m : xa_m), 3'b000};
          mb    <= {(swap ? xa_m : xb_m), 3'b000};
          cnt   <= (32'(d) > CAP) ? CW'(CAP) : CW'(d);
          state <= (d == '0) ? ADD : ALIGN;
        end
        ALIGN: begin
          // bits leaving the round position accumulate in sticky
          mb  <= {1'b0, mb[DW-1:2], mb[1] | mb[0]};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= ADD;
        end
        ADD: begin
          if (sum[DW]) begin
            ma <= {sum[DW:2], sum[1] | sum[0]};
            ea <= ea_inc;
            if (ea == EW'(EMAX)) begin
              out       <= {sa, {(W-1){1'b1}}};
              ovf       <= 1'b1;
              unf       <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= ROUND;
            end
          end else begin
            ma    <= sum[DW-1:0];
            state <= sum[DW-1] ? ROUND : NORM;
          end
        end
        NORM: begin
          if (ma == '0) begin
            out       <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (ma[DW-1]) begin
            state <= ROUND;
          end else if (ea == EW'(1)) begin
            // one more shift would reach exponent 0: flush
            out       <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            ma <= ma << 1;
            ea <= ea - EW'(1);
            if (ma[DW-2]) state <= ROUND;
          end
        end
        ROUND: begin
          ovf       <= 1'b0;
          unf       <= 1'b0;
          out_valid <= 1'b1;
          state     <= DONE;
          if (mrnd[MAN_W+1]) begin
            if (ea == EW'(EMAX)) begin
              out <= {sa, {(W-1){1'b1}}};
              ovf <= 1'b1;
            end else begin
              out <= {sa, ea_inc[EXP_W-1:0], {MAN_W{1'b0}}};
            end
          end else begin
            out <= {sa, ea[EXP_W-1:0], mrnd[MAN_W-1:0]};
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Bench for fp_addsub_seq (default 10-bit format): exact-arithmetic reference model, scoreboard, directed and random cases.
module tb_fp_addsub_seq;
  localparam int unsigned EXP_W = 4;
  localparam int unsigned MAN_W = 5;
  localparam int unsigned W     = 10;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, op, out_valid, out_ready, ovf, unf;
  logic [W-1:0] a, b, out;
  int           tests = 0;
  int           fails = 0;
  logic [W+1:0] exp_q[$];

  always #5 clk = ~clk;

  fp_addsub_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .ovf(ovf), .unf(unf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Exact value: sig * 2^(e-1) in units of the smallest normal LSB; round the exact sum.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
    longint va, vb, s, m, q, rem, half;
    int p, sh, e;
    logic sg;
    logic [3:0] ex, ey;
    ex = x[8:5];
    ey = y[8:5];
    va = (ex == 4'd0) ? 64'sd0 : (longint'({1'b1, x[4:0]}) <<< (int'(ex) - 1));
    vb = (ey == 4'd0) ? 64'sd0 : (longint'({1'b1, y[4:0]}) <<< (int'(ey) - 1));
    if (x[9]) va = -va;
    if (y[9] ^ sub) vb = -vb;
    s = va + vb;
    if (s == 0) return '0;
    sg = (s < 0);
    m  = sg ? -s : s;
    p  = 0;
    for (int i = 0; i < 40; i++) if (m[i]) p = i;
    if (p < int'(MAN_W)) return {10'd0, 2'b01};
    sh  = p - int'(MAN_W);
    e   = sh + 1;
    q   = m >>> sh;
    rem = m - (q <<< sh);
`ifdef FP_RNE_EN
    if (sh > 0) begin
      half = 64'sd1 <<< (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
    end
`else
    half = 0;
    if (rem < half) q = q - 1;
`endif
    if (q == 64) begin
      q = 32;
      e = e + 1;
    end
    if (e > 15) return {sg, 9'h1ff, 2'b10};
    return {sg, 4'(e), 5'(q), 2'b00};
  endfunction

  // Scoreboard: every accepted result is compared with the model
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got %0h with no pending operation", {out, ovf, unf});
      end else begin
        chk("scoreboard", {20'd0, out, ovf, unf}, {20'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic top);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles", n);
    end
    a = ta; b = tb; op = top; in_valid = 1'b1;
    exp_q.push_back(model(ta, tb, top));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // lat = cycle distance from the in_valid cycle to the first out_valid cycle
  task automatic wait_result(output int lat);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    lat = n + 1;
    if (!out_valid) begin
      tests++;
      fails++;
      $display("FAIL result_timeout: out_valid stayed 0 for %0d cycles", n);
    end
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic dir(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb, input logic top,
                     input logic [W-1:0] eo, input logic eov, input logic eun, output int lat);
    chk({name, "_model"}, {20'd0, model(ta, tb, top)}, {20'd0, eo, eov, eun});
    issue(ta, tb, top);
    wait_result(lat);
    chk({name, "_out"}, {20'd0, out, ovf, unf}, {20'd0, eo, eov, eun});
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [W-1:0] ta, tb;
    logic top;
    rst = 1'b1; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out", 32'(out), 0);
    chk("rst_flags", {30'd0, ovf, unf}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    dir("t1_add", 10'b0100101100, 10'b0100011000, 1'b0, 10'b0101000100, 1'b0, 1'b0, lat);
    chk("t1_latency", 32'(lat), 5);
    dir("t2_cancel", 10'b1100101100, 10'b0100101100, 1'b0, 10'b0000000000, 1'b0, 1'b0, lat);
    dir("t2_sub", 10'b0100110000, 10'b0100010000, 1'b1, 10'b0100010000, 1'b0, 1'b0, lat);
    dir("t3_double", 10'b0101101111, 10'b0101101111, 1'b0, 10'b0110001111, 1'b0, 1'b0, lat);
    chk("t3_latency_d0", 32'(lat), 4);
    dir("t3_ovf", 10'b0111111111, 10'b0111111111, 1'b0, 10'b0111111111, 1'b1, 1'b0, lat);
    dir("t4_unf", 10'b0001000000, 10'b0000111111, 1'b1, 10'b0000000000, 1'b0, 1'b1, lat);
`ifdef FP_RNE_EN
    dir("t5_round", 10'b0011100000, 10'b0001010000, 1'b0, 10'b0011100010, 1'b0, 1'b0, lat);
`else
    dir("t5_round", 10'b0011100000, 10'b0001010000, 1'b0, 10'b0011100001, 1'b0, 1'b0, lat);
`endif

    // Back-pressure: result must hold, further inputs ignored
    out_ready = 1'b0;
    issue(10'b0100101100, 10'b0100011000, 1'b0);
    wait_result(lat);
    for (int i = 0; i < 5; i++) begin
      a = 10'($urandom); b = 10'($urandom); in_valid = 1'b1;
      @(posedge clk); #1;
      chk("t6_hold_valid", 32'(out_valid), 1);
      chk("t6_hold_out", 32'(out), 32'(10'b0101000100));
      chk("t6_in_ready_low", 32'(in_ready), 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t6_released", 32'(out_valid), 0);
    chk("t6_in_ready_back", 32'(in_ready), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_no_extra", 32'(out_valid), 0);

    // Reset during ALIGN discards the operation
    issue(10'b0111000000, 10'b0001000000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_out_valid", 32'(out_valid), 0);
    chk("t6_rst_in_ready", 32'(in_ready), 1);
    chk("t6_rst_out", 32'(out), 0);
    exp_q.delete();
    rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("t6_rst_no_result", 32'(out_valid), 0);
    dir("t6_recover", 10'b0100101100, 10'b0100011000, 1'b0, 10'b0101000100, 1'b0, 1'b0, lat);

    // Random operations, half with nearby exponents to exercise cancellation
    for (int i = 0; i < 400; i++) begin
      ta  = 10'($urandom);
      tb  = 10'($urandom);
      top = 1'($urandom);
      if ($urandom_range(0, 1) == 1) tb[8:5] = ta[8:5] + 4'($urandom_range(0, 2)) - 4'd1;
      issue(ta, tb, top);
      wait_result(lat);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
